// File: rtl/wait_fare_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wait_fare_pkg
// Purpose  : Shared state encoding and helpers for the waiting-fare engine.
// Revision : 1.0 - initial release
// ============================================================================
package wait_fare_pkg;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_grace = 2'd1;
  localparam logic [1:0] c_st_bill  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = c_st_idle,
    ST_GRACE = c_st_grace,
    ST_BILL  = c_st_bill
  } state_t;

  // Increment that sticks at max_v; callers cast to their own counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wait_unit_counter.sv
`default_nettype none
// ============================================================================
// Module   : wait_unit_counter
// Purpose  : Modulo-len counter with enable and synchronous clear; term marks
//            the enabled count that wraps back to zero.
// Revision : 1.0 - initial release
// ============================================================================
module wait_unit_counter
  import wait_fare_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] len,
  output logic             term
);

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;
  logic             w_wrap;

  // >= rather than == so a shorter length chosen mid-unit still wraps.
  assign w_last = len - c_one;
  assign w_wrap = (r_cnt >= w_last);
  assign term   = en & w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + c_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wait_fare_timer.sv
`default_nettype none
// ============================================================================
// Module   : wait_fare_timer
// Purpose  : Waiting-time billing engine: free grace minutes per trip, then one
//            wait_fare_pulse per billing unit. Night rate: WAIT_NIGHT_RATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wait_fare_timer
  import wait_fare_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int FREE_MIN       = 5,
  parameter int UNIT_MIN       = 3,
  parameter int NIGHT_UNIT_MIN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trip_active,
  input  logic             waiting,
  input  logic             min_tick,
  input  logic             night,
  output logic             wait_fare_pulse,
  output logic [CNT_W-1:0] wait_minutes,
  output logic             billing
);

  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_free = CNT_W'(FREE_MIN);
  localparam logic [CNT_W-1:0] c_max  = {CNT_W{1'b1}};

  state_t           r_state;
  logic [CNT_W-1:0] r_grace;
  logic [CNT_W-1:0] r_wait_minutes;
  logic             r_pulse;
  logic             r_billing;

  logic             w_tick;
  logic [CNT_W-1:0] w_len;
  logic [CNT_W-1:0] w_grace_next;
  logic [CNT_W-1:0] w_wait_inc;
  logic             w_unit_en;
  logic             w_unit_clr;
  logic             w_unit_term;

  assign w_tick       = min_tick & waiting & trip_active & (r_state != ST_IDLE);
  assign w_grace_next = r_grace + c_one;
  assign w_wait_inc   = CNT_W'(sat_inc(32'(r_wait_minutes), 32'(c_max)));

`ifdef WAIT_NIGHT_RATE_EN
  assign w_len = night ? CNT_W'(NIGHT_UNIT_MIN) : CNT_W'(UNIT_MIN);
`else
  logic [CNT_W:0] w_unused_night;
  assign w_unused_night = {night, CNT_W'(NIGHT_UNIT_MIN)};
  assign w_len          = CNT_W'(UNIT_MIN);
`endif

  // A partial unit is discarded whenever the trip ends or a new one begins.
  assign w_unit_en  = w_tick & (r_state == ST_BILL);
  assign w_unit_clr = ~trip_active | (r_state == ST_IDLE);

  wait_unit_counter #(
    .CNT_W (CNT_W)
  ) u_unit (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_unit_clr),
    .en    (w_unit_en),
    .len   (w_len),
    .term  (w_unit_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_grace        <= '0;
      r_wait_minutes <= '0;
      r_pulse        <= 1'b0;
      r_billing      <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (!trip_active) begin
        r_state   <= ST_IDLE;
        r_billing <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_wait_minutes <= '0;
            r_grace        <= '0;
            if (FREE_MIN == 0) begin
              r_state   <= ST_BILL;
              r_billing <= 1'b1;
            end else begin
              r_state <= ST_GRACE;
            end
          end
          ST_GRACE: begin
            if (w_tick) begin
              r_grace        <= w_grace_next;
              r_wait_minutes <= w_wait_inc;
              if (w_grace_next == c_free) begin
                r_state   <= ST_BILL;
                r_billing <= 1'b1;
              end
            end
          end
          ST_BILL: begin
            if (w_tick) begin
              r_wait_minutes <= w_wait_inc;
              r_pulse        <= w_unit_term;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_billing <= 1'b0;
          end
        endcase
      end
    end
  end

  assign wait_fare_pulse = r_pulse;
  assign wait_minutes    = r_wait_minutes;
  assign billing         = r_billing;

endmodule
`default_nettype wire

// File: tb/tb_wait_fare_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wait_fare_timer
// Purpose  : Directed plus random bench for wait_fare_timer (8- and 4-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wait_fare_timer;

  localparam int FREE  = 5;
  localparam int UNIT  = 3;
  localparam int NIGHT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trip_active, waiting, min_tick, night;
  logic       pulse_a, billing_a, pulse_b, billing_b;
  logic [7:0] wm_a;
  logic [3:0] wm_b;

  int n_vec = 0;
  int n_err = 0;
  int pc_a  = 0;

  // Reference model state: whole-trip bookkeeping in plain integers.
  bit m_on;
  int m_free, m_unit, m_total;
  bit e_pulse, e_bill;

  always #5 clk = ~clk;

  wait_fare_timer dut (
    .clk(clk), .rst_n(rst_n), .trip_active(trip_active), .waiting(waiting),
    .min_tick(min_tick), .night(night), .wait_fare_pulse(pulse_a),
    .wait_minutes(wm_a), .billing(billing_a)
  );

  wait_fare_timer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .trip_active(trip_active), .waiting(waiting),
    .min_tick(min_tick), .night(night), .wait_fare_pulse(pulse_b),
    .wait_minutes(wm_b), .billing(billing_b)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  function automatic int unit_len(input bit n);
`ifdef WAIT_NIGHT_RATE_EN
    return n ? NIGHT : UNIT;
`else
    return UNIT;
`endif
  endfunction

  task automatic model_reset();
    m_on = 0; m_free = 0; m_unit = 0; m_total = 0; e_pulse = 0; e_bill = 0;
  endtask

  task automatic model_edge(input bit ta, input bit w, input bit t, input bit n);
    e_pulse = 0;
    if (!ta) begin
      m_on = 0; m_unit = 0; e_bill = 0;
    end else if (!m_on) begin
      m_on = 1; m_free = 0; m_unit = 0; m_total = 0; e_bill = (FREE == 0);
    end else if (t && w) begin
      m_total++;
      if (m_free < FREE) begin
        m_free++;
        e_bill = (m_free == FREE);
      end else begin
        m_unit++;
        if (m_unit >= unit_len(n)) begin
          e_pulse = 1;
          m_unit  = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    if (pulse_a === 1'b1) pc_a++;
    check("pulse8",   32'(pulse_a),   int'(e_pulse));
    check("billing8", 32'(billing_a), int'(e_bill));
    check("wmin8",    32'(wm_a),      (m_total > 255) ? 255 : m_total);
    check("pulse4",   32'(pulse_b),   int'(e_pulse));
    check("billing4", 32'(billing_b), int'(e_bill));
    check("wmin4",    32'(wm_b),      (m_total > 15) ? 15 : m_total);
  endtask

  // Inputs change at the falling edge, are captured on the rising edge,
  // and outputs are compared on the following falling edge.
  task automatic step(input bit ta, input bit w, input bit t, input bit n);
    trip_active = ta; waiting = w; min_tick = t; night = n;
    @(posedge clk);
    model_edge(ta, w, t, n);
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int cnt, input bit w, input bit n);
    for (int i = 0; i < cnt; i++) begin
      step(1, w, 1, n);
      step(1, w, 0, n);
    end
  endtask

  initial begin
    rst_n = 0; trip_active = 0; waiting = 0; min_tick = 0; night = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    check_all();

    // 1: grace of 5, then pulses after ticks 8 and 11
    pc_a = 0;
    step(1, 1, 0, 0);
    ticks(5, 1, 0);
    check("t1_bill_after_grace", 32'(billing_a), 1);
    check("t1_no_grace_pulse", 32'(pc_a), 0);
    ticks(6, 1, 0);
    check("t1_wmin", 32'(wm_a), 11);
    check("t1_pulses", 32'(pc_a), 2);
    step(0, 0, 0, 0);

    // 2: grace is cumulative across a moving interval
    pc_a = 0;
    step(1, 0, 0, 0);
    ticks(3, 1, 0);
    ticks(4, 0, 0);
    check("t2_still_grace", 32'(billing_a), 0);
    ticks(5, 1, 0);
    check("t2_wmin", 32'(wm_a), 8);
    check("t2_pulses", 32'(pc_a), 1);
    step(0, 0, 0, 0);

    // 3: trip ends on the tick that would bill
    pc_a = 0;
    step(1, 1, 0, 0);
    ticks(7, 1, 0);
    step(0, 1, 1, 0);
    check("t3_no_pulse", 32'(pc_a), 0);
    check("t3_idle", 32'(billing_a), 0);
    check("t3_wmin_held", 32'(wm_a), 7);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("t3_wmin_clear", 32'(wm_a), 0);

    // 4: 4-bit counter saturates while billing continues
    pc_a = 0;
    ticks(20, 1, 0);
    check("t4_sat4", 32'(wm_b), 15);
    check("t4_wmin8", 32'(wm_a), 20);
    check("t4_pulses", 32'(pc_a), 5);
    step(0, 0, 0, 0);

    // 5: night rate after grace
    step(1, 1, 0, 0);
    ticks(5, 1, 0);
    pc_a = 0;
    ticks(6, 1, 1);
`ifdef WAIT_NIGHT_RATE_EN
    check("t5_night_pulses", 32'(pc_a), 3);
`else
    check("t5_night_pulses", 32'(pc_a), 2);
`endif
    step(0, 0, 0, 0);

    // 6: asynchronous reset mid-BILL restarts the free period
    step(1, 1, 0, 0);
    ticks(7, 1, 0);
    trip_active = 1; waiting = 1; min_tick = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    check("t6_rst_pulse", 32'(pulse_a), 0);
    check("t6_rst_bill", 32'(billing_a), 0);
    check("t6_rst_wmin", 32'(wm_a), 0);
    check("t6_rst_wmin4", 32'(wm_b), 0);
    @(negedge clk);
    rst_n = 1;
    pc_a = 0;
    step(1, 1, 0, 0);
    ticks(4, 1, 0);
    check("t6_regrace", 32'(billing_a), 0);
    ticks(1, 1, 0);
    check("t6_bill_again", 32'(billing_a), 1);
    check("t6_no_pulse", 32'(pc_a), 0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 2) == 0), 1'($urandom % 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
